delay_meas: RTL and testbench
=============================

Name: delay_meas

Overview:
- Measures the latency, in clk cycles, between an event injected at the input of a delay path and the same event observed at its far end.
- Averages 2^LOG_AVG measurements and presents a rounded delay value sized to drive the delay select input of data_delay directly.
- Used for calibration and alignment of parallel data paths.
- Timeouts are detected and reported.

Parameters:
- MAX_DELAY, 16: largest measurable latency in cycles; the matching data_delay uses the same value.
- LOG_AVG, 2: log2 of the number of measurements averaged per campaign; the legal range is 0..8.
- DELAY_WIDTH, $clog2(MAX_DELAY+1): localparam, width of delay values.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a measurement campaign.
- ref_stb  in  1  event injected at the delay path input.
- echo_stb  in  1  event observed at the delay path output.
- delay_out  out  DELAY_WIDTH  averaged, rounded latency.
- delay_valid  out  1  delay_out holds a completed campaign result.
- busy  out  1  a campaign is in progress.
- timeout_err  out  1  the last campaign aborted because no echo arrived.

Behaviour:
- Reset (asynchronous, active-high) sets delay_out=0, delay_valid=0, busy=0, timeout_err=0, state=IDLE, and clears the accumulator and counters.
  - A reset mid-campaign discards all partial results.
- Internal registers:
  - cnt, DELAY_WIDTH bits: cycle counter.
  - acc, DELAY_WIDTH+LOG_AVG bits: sample accumulator.
  - n, LOG_AVG+1 bits: completed samples.
- State IDLE:
  - busy=0.
  - start=1 sets acc=0, n=0, timeout_err=0, delay_valid=0, and moves to WAIT_REF.
- State WAIT_REF:
  - busy=1.
  - echo_stb without ref_stb is ignored.
  - ref_stb=1 with echo_stb=1 in the same cycle records sample=0.
  - ref_stb=1 with echo_stb=0 sets cnt=1 and moves to COUNT.
- State COUNT:
  - busy=1. ref_stb is ignored.
  - echo_stb=1 records sample=cnt.
  - No echo and cnt==MAX_DELAY is a timeout: timeout_err=1, move to IDLE. delay_out is unchanged; delay_valid stays 0.
  - Otherwise cnt increments.
- Latency definition: an echo k cycles after ref_stb (k=0 meaning the same cycle) records sample k. Samples range 0..MAX_DELAY inclusive.
- Recording a sample (on the clock edge that samples echo_stb):
  - acc += sample; n += 1.
  - If n reaches 2^LOG_AVG, the campaign completes on the same edge:
    - delay_out = (acc_final + 2^(LOG_AVG-1)) >> LOG_AVG, i.e. round half up. The rounding term is 0 when LOG_AVG=0.
    - The result is always ≤ MAX_DELAY, so no saturation is needed.
    - delay_valid=1, move to IDLE.
  - Otherwise return to WAIT_REF.
- Result timing: delay_out and delay_valid change on the edge sampling the final echo and are visible the following cycle.
- delay_valid and delay_out hold until the next accepted start or reset.
- start is ignored while busy=1. A start pulse arriving in the same cycle as a campaign completion or timeout (the state at that edge is not IDLE) is ignored.
- acc cannot overflow: the maximum sum is MAX_DELAY·2^LOG_AVG.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package delay_pkg holds:
  - enum meas_state_t {IDLE, WAIT_REF, COUNT};
  - a function computing the delay width, $clog2(max+1). data_delay and delay_meas use it so both agree on DELAY_WIDTH.
- No sub-module: counter, accumulator and FSM stay in one module. A sub-module would add only port overhead.

Test Plan:
- Single measurement, MAX_DELAY=16, LOG_AVG=0: start; ref_stb at cycle 10, echo_stb at cycle 15 -> delay_out=5, delay_valid=1 at cycle 16, busy falls at cycle 16.
- Averaging with rounding, LOG_AVG=2: samples 3,3,4,4 (sum 14, 3.5) -> delay_out=4. Samples 3,4,4,5 -> delay_out=4. Samples 0,0,0,1 -> delay_out=0.
- Boundaries: echo in the same cycle as ref -> sample 0. Echo exactly 16 cycles after ref -> sample 16 accepted, delay_out=16.
- Timeout: echo never arrives after ref -> timeout_err=1 and busy=0 the cycle after cnt reaches 16. delay_valid=0, delay_out keeps the previous value. The next start clears timeout_err.
- Protocol robustness:
  - start while busy -> ignored, campaign unaffected.
  - Extra ref_stb during COUNT -> ignored.
  - echo_stb in IDLE or WAIT_REF without ref_stb -> ignored, no sample recorded.
- Reset mid-campaign: assert rst asynchronously during COUNT after 2 of 4 samples -> all outputs 0 immediately. A new campaign then averages only post-reset samples.

Source files
------------

// File: rtl/delay_pkg.sv
// Types and helpers shared by delay_meas and data_delay so both agree on
// the encoding of delay values.
package delay_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_REF,
    COUNT
  } meas_state_t;

  function automatic int delay_width(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

endpackage

// File: rtl/delay_meas.sv
// Measures ref_stb -> echo_stb latency in clk cycles, averages 2^LOG_AVG
// samples and rounds half up into a value that drives data_delay directly.
module delay_meas
  import delay_pkg::*;
#(
  parameter int MAX_DELAY = 16,
  parameter int LOG_AVG   = 2,
  localparam int DELAY_WIDTH = delay_width(MAX_DELAY)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   ref_stb,
  input  logic                   echo_stb,
  output logic [DELAY_WIDTH-1:0] delay_out,
  output logic                   delay_valid,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int ACC_W = DELAY_WIDTH + LOG_AVG;
  localparam logic [ACC_W:0] ROUND = (ACC_W+1)'((1 << LOG_AVG) >> 1);
  localparam logic [DELAY_WIDTH-1:0] MAX_CNT = DELAY_WIDTH'(MAX_DELAY);

  meas_state_t            state, state_d;
  logic [DELAY_WIDTH-1:0] cnt, cnt_d;
  logic [ACC_W-1:0]       acc, acc_d, acc_sum;
  logic [LOG_AVG:0]       n, n_d, n_inc;
  logic [DELAY_WIDTH-1:0] out_d, sample;
  logic                   valid_d, err_d, rec;
  logic [ACC_W:0]         rnd_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      n           <= '0;
      delay_out   <= '0;
      delay_valid <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      acc         <= acc_d;
      n           <= n_d;
      delay_out   <= out_d;
      delay_valid <= valid_d;
      busy        <= (state_d != IDLE);
      timeout_err <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    acc_d   = acc;
    n_d     = n;
    out_d   = delay_out;
    valid_d = delay_valid;
    err_d   = timeout_err;
    rec     = 1'b0;
    sample  = '0;

    case (state)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          n_d     = '0;
          err_d   = 1'b0;
          valid_d = 1'b0;
          state_d = WAIT_REF;
        end
      end
      WAIT_REF: begin
        if (ref_stb) begin
          if (echo_stb) begin
            rec = 1'b1;
          end else begin
            cnt_d   = DELAY_WIDTH'(1);
            state_d = COUNT;
          end
        end
      end
      COUNT: begin
        if (echo_stb) begin
          rec    = 1'b1;
          sample = cnt;
        end else if (cnt == MAX_CNT) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // n counts 0..2^LOG_AVG-1, so its top bit after increment marks the last sample
    acc_sum = acc + ACC_W'(sample);
    n_inc   = n + 1'b1;
    rnd_sum = {1'b0, acc_sum} + ROUND;

    if (rec) begin
      acc_d = acc_sum;
      n_d   = n_inc;
      if (n_inc[LOG_AVG]) begin
        out_d   = DELAY_WIDTH'(rnd_sum >> LOG_AVG);
        valid_d = 1'b1;
        state_d = IDLE;
      end else begin
        state_d = WAIT_REF;
      end
    end
  end

endmodule

// File: tb/tb_delay_meas.sv
// Randomized self-checking bench for delay_meas: a 4-sample averaging
// instance with an integer reference model and a single-sample instance.
module tb_delay_meas;

  localparam int MAXD = 16;
  localparam int DW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          start = 0, ref_stb = 0, echo_stb = 0;
  logic [DW-1:0] delay_out;
  logic          delay_valid, busy, timeout_err;

  logic          start0 = 0, ref0 = 0, echo0 = 0;
  logic [DW-1:0] delay_out0;
  logic          delay_valid0, busy0, timeout_err0;

  int errors = 0;
  int checks = 0;
  int exp_out = 0;

  delay_meas #(.MAX_DELAY(MAXD), .LOG_AVG(2)) dut (
    .clk(clk), .rst(rst), .start(start), .ref_stb(ref_stb), .echo_stb(echo_stb),
    .delay_out(delay_out), .delay_valid(delay_valid), .busy(busy),
    .timeout_err(timeout_err)
  );

  delay_meas #(.MAX_DELAY(MAXD), .LOG_AVG(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .ref_stb(ref0), .echo_stb(echo0),
    .delay_out(delay_out0), .delay_valid(delay_valid0), .busy(busy0),
    .timeout_err(timeout_err0)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one ref/echo pair with echo k cycles after ref.
  task automatic do_sample(input int k, input bit noise, input bit start_last);
    ref_stb  = 1'b1;
    echo_stb = (k == 0);
    start    = (k == 0) && start_last;
    tick();
    ref_stb = 1'b0; echo_stb = 1'b0; start = 1'b0;
    if (k > 0) begin
      for (int i = 1; i < k; i++) begin
        ref_stb = noise && ($urandom_range(0, 1) != 0);
        start   = noise && ($urandom_range(0, 1) != 0);
        tick();
      end
      ref_stb  = 1'b0;
      start    = start_last;
      echo_stb = 1'b1;
      tick();
      echo_stb = 1'b0;
      start    = 1'b0;
    end
  endtask

  task automatic run_campaign(input int s0, input int s1, input int s2, input int s3,
                              input bit noise, input bit start_last, input string name);
    int s[4];
    int sum;
    s = '{s0, s1, s2, s3};
    sum = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || delay_valid !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL %s start: busy=%b valid=%b err=%b want 1 0 0", name, busy, delay_valid, timeout_err);
    end
    for (int i = 0; i < 4; i++) begin
      if (noise) begin
        for (int g = $urandom_range(0, 3); g > 0; g--) begin
          echo_stb = ($urandom_range(0, 1) != 0);
          tick();
        end
        echo_stb = 1'b0;
      end
      do_sample(s[i], noise, start_last && (i == 3));
      sum += s[i];
      if (i < 3) begin
        checks++;
        if (busy !== 1'b1 || delay_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s mid sample %0d: busy=%b valid=%b want 1 0", name, i, busy, delay_valid);
        end
      end
    end
    exp_out = (sum + 2) / 4;
    checks++;
    if (int'(delay_out) !== exp_out || delay_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s result: out=%0d valid=%b busy=%b want %0d 1 0", name, delay_out,
               delay_valid, busy, exp_out);
    end
    if (start_last) begin
      tick();
      checks++;
      if (delay_valid !== 1'b1 || busy !== 1'b0 || int'(delay_out) !== exp_out) begin
        errors++;
        $display("FAIL %s start_at_end: valid=%b busy=%b out=%0d want 1 0 %0d", name,
                 delay_valid, busy, delay_out, exp_out);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (delay_out !== '0 || delay_valid !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: out=%0d valid=%b busy=%b err=%b want 0", delay_out, delay_valid, busy, timeout_err);
    end
    checks++;
    if (delay_out0 !== '0 || delay_valid0 !== 1'b0 || busy0 !== 1'b0 || timeout_err0 !== 1'b0) begin
      errors++;
      $display("FAIL reset0: out=%0d valid=%b busy=%b err=%b want 0", delay_out0, delay_valid0, busy0, timeout_err0);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (8) tick();
    ref0 = 1'b1;
    tick();
    ref0 = 1'b0;
    repeat (4) tick();
    checks++;
    if (busy0 !== 1'b1 || delay_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL single pending: busy=%b valid=%b want 1 0", busy0, delay_valid0);
    end
    echo0 = 1'b1;
    tick();
    echo0 = 1'b0;
    checks++;
    if (delay_out0 !== 5'd5 || delay_valid0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL single: out=%0d valid=%b busy=%b want 5 1 0", delay_out0, delay_valid0, busy0);
    end
  endtask

  task automatic test_averaging();
    run_campaign(3, 3, 4, 4, 1'b0, 1'b0, "avg_3344");
    run_campaign(3, 4, 4, 5, 1'b0, 1'b0, "avg_3445");
    run_campaign(0, 0, 0, 1, 1'b0, 1'b0, "avg_0001");
  endtask

  task automatic test_boundaries();
    run_campaign(0, 0, 0, 0, 1'b0, 1'b0, "bound_zero");
    run_campaign(16, 16, 16, 16, 1'b0, 1'b1, "bound_max");
    run_campaign(0, 16, 1, 15, 1'b1, 1'b1, "bound_mix");
  endtask

  task automatic test_random();
    for (int c = 0; c < 8; c++)
      run_campaign($urandom_range(0, MAXD), $urandom_range(0, MAXD), $urandom_range(0, MAXD),
                   $urandom_range(0, MAXD), 1'b1, 1'b0, "random");
  endtask

  task automatic test_timeout();
    start = 1'b1;
    tick();
    start = 1'b0;
    do_sample(7, 1'b0, 1'b0);
    ref_stb = 1'b1;
    tick();
    ref_stb = 1'b0;
    repeat (15) tick();
    checks++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout early: busy=%b err=%b want 1 0", busy, timeout_err);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b1 || delay_valid !== 1'b0 || int'(delay_out) !== exp_out) begin
      errors++;
      $display("FAIL timeout: busy=%b err=%b valid=%b out=%0d want 0 1 0 %0d", busy, timeout_err,
               delay_valid, delay_out, exp_out);
    end
    echo_stb = 1'b1;
    repeat (3) tick();
    echo_stb = 1'b0;
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b1 || int'(delay_out) !== exp_out) begin
      errors++;
      $display("FAIL timeout hold: busy=%b err=%b out=%0d want 0 1 %0d", busy, timeout_err, delay_out, exp_out);
    end
    run_campaign(2, 9, 6, 1, 1'b1, 1'b0, "after_timeout");
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    tick();
    start = 1'b0;
    do_sample(9, 1'b0, 1'b0);
    do_sample(11, 1'b0, 1'b0);
    ref_stb = 1'b1;
    tick();
    ref_stb = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (delay_out !== '0 || delay_valid !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: out=%0d valid=%b busy=%b err=%b want 0", delay_out, delay_valid, busy, timeout_err);
    end
    exp_out = 0;
    tick();
    rst = 1'b0;
    tick();
    run_campaign(1, 2, 2, 2, 1'b0, 1'b0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_averaging();
    test_boundaries();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
